// File: rtl/bcd2bin.sv
// Sequential BCD-to-binary converter using reverse double-dabble.
// It performs one shift/correct iteration per clock and frames each conversion with start/busy/valid.
module bcd2bin #(
    parameter int DIGITS = 3,
    parameter int BIN_W  = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   bcd_in,
    output logic                  busy,
    output logic                  valid,
    output logic [BIN_W-1:0]      bin,
    output logic                  err
);
    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(BIN_W - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t              state, state_nxt;
    logic [BCD_W-1:0]    bcd_sr, bcd_sr_nxt;
    logic [BIN_W-1:0]    res, res_nxt, res_shift;
    logic [CNT_W-1:0]    cnt, cnt_nxt;
    logic                err_pending, err_pending_nxt;
    logic                busy_nxt, valid_nxt, err_nxt;
    logic [BIN_W-1:0]    bin_nxt;

    // After a right shift, a digit MSB that arrived from the digit above is worth 5, not 8.
    function automatic logic [BCD_W-1:0] fix_digits(input logic [BCD_W-1:0] v);
        logic [BCD_W-1:0] r;
        r = v;
        for (int i = 0; i < DIGITS; i++) begin
            if (v[4*i+3]) r[4*i +: 4] = v[4*i +: 4] - 4'd3;
        end
        return r;
    endfunction

    function automatic logic has_bad_digit(input logic [BCD_W-1:0] v);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (v[4*i +: 4] > 4'd9) bad = 1'b1;
        end
        return bad;
    endfunction

    always_comb begin
        state_nxt       = state;
        bcd_sr_nxt      = bcd_sr;
        res_nxt         = res;
        cnt_nxt         = cnt;
        err_pending_nxt = err_pending;
        busy_nxt        = busy;
        valid_nxt       = 1'b0;
        bin_nxt         = bin;
        err_nxt         = err;
        res_shift       = {bcd_sr[0], res[BIN_W-1:1]};
        case (state)
            IDLE: begin
                if (start) begin
                    bcd_sr_nxt      = bcd_in;
                    res_nxt         = '0;
                    err_pending_nxt = has_bad_digit(bcd_in);
                    cnt_nxt         = '0;
                    busy_nxt        = 1'b1;
                    state_nxt       = SHIFT;
                end
            end
            SHIFT: begin
                res_nxt    = res_shift;
                bcd_sr_nxt = fix_digits(bcd_sr >> 1);
                cnt_nxt    = cnt + CNT_W'(1);
                if (cnt == LAST) begin
                    bin_nxt   = err_pending ? '0 : res_shift;
                    err_nxt   = err_pending;
                    valid_nxt = 1'b1;
                    busy_nxt  = 1'b0;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            busy  <= 1'b0;
            valid <= 1'b0;
            bin   <= '0;
            err   <= 1'b0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            busy  <= busy_nxt;
            valid <= valid_nxt;
            bin   <= bin_nxt;
            err   <= err_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Working registers are only meaningful while SHIFT, so they carry no reset.
    always_ff @(posedge clk) begin
        bcd_sr      <= bcd_sr_nxt;
        res         <= res_nxt;
        err_pending <= err_pending_nxt;
    end
endmodule

// File: tb/tb_bcd2bin.sv
// Directed bench for bcd2bin: a vector table for single conversions plus hand-written
// sequences for busy-start rejection, back-to-back starts and mid-conversion reset.
module tb_bcd2bin;
    logic        clk;
    logic        rst;
    logic        start;
    logic [11:0] bcd_in;
    logic        busy;
    logic        valid;
    logic [9:0]  bin;
    logic        err;

    int checks = 0;
    int errors = 0;

    bcd2bin #(.DIGITS(3), .BIN_W(10)) dut (
        .clk(clk), .rst(rst), .start(start), .bcd_in(bcd_in),
        .busy(busy), .valid(valid), .bin(bin), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [11:0] bcd;
        logic [9:0]  exp_bin;
        logic        exp_err;
    } vec_t;

    vec_t vecs[10];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Start one conversion and check latency, result, handshake and hold.
    task automatic do_conv(input logic [11:0] b, input logic [9:0] eb, input logic ee);
        int cyc;
        string nm;
        nm = $sformatf("conv_%03h", b);
        start  = 1'b1;
        bcd_in = b;
        step();
        start  = 1'b0;
        bcd_in = 12'hFFF;
        check({nm, "_busy"}, int'(busy), 1);
        cyc = 0;
        while (!valid && cyc < 20) begin
            step();
            cyc++;
        end
        check({nm, "_latency"}, cyc, 10);
        check({nm, "_bin"}, int'(bin), int'(eb));
        check({nm, "_err"}, int'(err), int'(ee));
        check({nm, "_busy_done"}, int'(busy), 0);
        step();
        check({nm, "_valid_pulse"}, int'(valid), 0);
        check({nm, "_bin_hold"}, int'(bin), int'(eb));
    endtask

    initial begin
        int nvalid;
        int vat;
        int cyc;

        vecs[0] = '{12'h255, 10'd255, 1'b0};
        vecs[1] = '{12'h999, 10'd999, 1'b0};
        vecs[2] = '{12'h000, 10'd0,   1'b0};
        vecs[3] = '{12'h100, 10'd100, 1'b0};
        vecs[4] = '{12'h1A5, 10'd0,   1'b1};
        vecs[5] = '{12'h042, 10'd42,  1'b0};
        vecs[6] = '{12'h009, 10'd9,   1'b0};
        vecs[7] = '{12'h010, 10'd10,  1'b0};
        vecs[8] = '{12'h980, 10'd980, 1'b0};
        vecs[9] = '{12'hF00, 10'd0,   1'b1};

        rst = 1'b1; start = 1'b0; bcd_in = '0;
        step();
        step();
        rst = 1'b0;
        check("reset_busy", int'(busy), 0);
        check("reset_valid", int'(valid), 0);
        check("reset_bin", int'(bin), 0);
        check("reset_err", int'(err), 0);

        for (int i = 0; i < 10; i++) begin
            do_conv(vecs[i].bcd, vecs[i].exp_bin, vecs[i].exp_err);
        end

        // Starts while busy must be ignored.
        start = 1'b1; bcd_in = 12'h123;
        step();
        nvalid = 0; vat = 0;
        for (int k = 1; k <= 25; k++) begin
            if (k == 3 || k == 7) begin
                start = 1'b1; bcd_in = 12'h999;
            end else begin
                start = 1'b0; bcd_in = 12'h000;
            end
            step();
            if (valid) begin
                nvalid++;
                if (nvalid == 1) begin
                    vat = k;
                    check("busy_start_bin", int'(bin), 123);
                end
            end
        end
        check("busy_start_nvalid", nvalid, 1);
        check("busy_start_latency", vat, 10);

        // Restart in the valid cycle.
        start = 1'b1; bcd_in = 12'h512;
        step();
        start = 1'b0;
        cyc = 0;
        while (!valid && cyc < 20) begin
            step();
            cyc++;
        end
        check("b2b_first_bin", int'(bin), 512);
        start = 1'b1; bcd_in = 12'h087;
        step();
        start = 1'b0; bcd_in = 12'h555;
        cyc = 1;
        while (!valid && cyc < 30) begin
            step();
            cyc++;
        end
        check("b2b_gap", cyc, 11);
        check("b2b_second_bin", int'(bin), 87);
        check("b2b_second_err", int'(err), 0);

        // Reset mid-conversion abandons the operation.
        step();
        start = 1'b1; bcd_in = 12'h777;
        step();
        start = 1'b0;
        for (int k = 1; k <= 4; k++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midrst_busy", int'(busy), 0);
        check("midrst_bin", int'(bin), 0);
        check("midrst_err", int'(err), 0);
        nvalid = 0;
        for (int k = 0; k < 15; k++) begin
            if (valid) nvalid++;
            step();
        end
        check("midrst_no_valid", nvalid, 0);
        do_conv(12'h777, 10'd777, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/bcd2bin.md
Name: bcd2bin

Overview:
Sequential BCD-to-binary converter. It is the inverse of the display-side binary-to-BCD path: it takes packed decimal digits from keypad or time-set entry and returns the binary value to the counter/compare logic. It uses a reverse double-dabble algorithm (shift right, then subtract 3 from every digit that is ≥8), one iteration per clock. A start/busy/valid handshake frames each conversion.

Parameters:
DIGITS, 3, number of BCD digits in bcd_in; digit 0 (ones) sits at bcd_in[3:0].
BIN_W, 10, output width and iteration count; must satisfy 2^BIN_W > 10^DIGITS - 1.

Ports:
clk  input  1  system clock; all state changes on its rising edge.
rst  input  1  synchronous, active-high reset.
start  input  1  request pulse; sampled only while busy=0.
bcd_in  input  4*DIGITS  packed BCD operand (hun/ten/one for the default).
busy  output  1  high while a conversion is in progress.
valid  output  1  one-cycle pulse; bin and err are valid in this cycle.
bin  output  BIN_W  converted value; held until the next valid.
err  output  1  set with valid if any input digit was >9; held with bin.

Behaviour:
- Reset: when rst=1 at a clk edge, the next state is IDLE; busy=0, valid=0, bin=0, err=0, iteration counter=0. rst has priority over all other inputs. Reset mid-conversion abandons the operation with no valid pulse.
- States: IDLE, SHIFT.
- IDLE, start=1 at edge N:
  - capture bcd_in into a 4*DIGITS shift register;
  - clear the BIN_W result register;
  - err_pending <= (any digit > 9);
  - cnt <= 0; busy <= 1; go to SHIFT.
- IDLE, start=0: hold; busy=0.
- SHIFT, one iteration per edge (edges N+1 .. N+BIN_W):
  - the BCD register LSB shifts into the result MSB, and the result shifts right by 1;
  - the BCD register shifts right by 1;
  - every 4-bit digit of the shifted BCD value that is ≥8 gets 3 subtracted (modulo 16 per digit);
  - cnt increments.
- Final iteration at edge N+BIN_W (cnt = BIN_W-1):
  - bin <= final result, or 0 if err_pending;
  - err <= err_pending; valid <= 1; busy <= 0; go to IDLE.
- Latency: start sampled at edge N produces valid high in the cycle after edge N+BIN_W (10 cycles for the default). Throughput is one conversion per BIN_W+1 cycles.
- valid is high for exactly one cycle. bin and err hold their values until the next completion or reset.
- start while busy=1 is ignored entirely; no queueing occurs.
- start=1 in the same cycle valid=1 is accepted, because the state is IDLE then. The back-to-back period is BIN_W+1 cycles.
- bcd_in is don't-care except at the capture edge. Changes during SHIFT have no effect.
- Invalid digit (>9): the conversion still runs its full latency for uniform timing. The output is forced to bin=0 with err=1.
- The result never exceeds 10^DIGITS-1 for valid input, so no overflow is possible given the BIN_W constraint.
- No combinational path from inputs to outputs; all outputs are registered.

Test Plan:
- Reset, then bcd_in=0x255 with start at edge N → busy high from N; valid=1 in cycle after edge N+10; bin=255 (0x0FF); err=0; busy=0 in the same cycle.
- bcd_in=0x999 → bin=999 (0x3E7), err=0. bcd_in=0x000 → bin=0, err=0. bcd_in=0x100 → bin=100.
- bcd_in=0x1A5 (ten digit=10) → after 10 cycles valid=1, err=1, bin=0. A following 0x042 → bin=42, err=0.
- Start at N with 0x123, then start pulses with 0x999 at N+3 and N+7 → only one valid at N+10 with bin=123; no second valid.
- Start 0x512; at the valid cycle, start again with 0x087 → first valid bin=512, second valid exactly 11 cycles later with bin=87.
- Start 0x777; rst=1 at edge N+5 → busy=0, bin=0, err=0 after that edge; no valid pulse ever appears for this operation. A new start after reset converts normally.
